clap_ctrl: RTL

CLAP_CTRL -- requirements
Module: clap_ctrl

---
 rtl/clap_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/clap_ctrl.sv
// Clap detector controller: feeds samples to an external FIR, tags which FIR
// outputs belong to real samples, and detects single/double claps on them.
//
//   state | meaning
//   IDLE  | waiting for a first clap
//   HOLD1 | ignoring outputs after the first clap
//   WIN   | a further clap in this window counts as a double
//   HOLD2 | ignoring outputs after a double clap
module clap_ctrl #(
  parameter int FIR_LAT = 1,
  parameter int HOLDOFF = 4,
  parameter int WINDOW  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic [7:0] fir_x,
  input  logic [9:0] fir_data,
  input  logic [9:0] threshold,
  input  logic       clear_count,
  output logic       clap,
  output logic       double_clap,
  output logic [7:0] clap_count,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, HOLD1, WIN, HOLD2} state_t;

  localparam logic [7:0] HOLD_INIT = 8'(HOLDOFF);
  localparam logic [7:0] WIN_INIT  = 8'(WINDOW);

  state_t             state, state_n;
  logic [7:0]         cnt, cnt_n;
  logic [FIR_LAT-1:0] tags;
  logic               accept, ov, hit;
  logic               clap_n, dbl_n;

  assign sample_ready = ~rst;
  assign accept       = sample_valid & sample_ready;
  assign ov           = tags[FIR_LAT-1];
  assign hit          = ov && (fir_data > threshold);
  assign busy         = (state != IDLE);

  // Sample register (zero-stuffed when nothing is accepted) and valid-tag delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fir_x <= 8'd0;
      tags  <= '0;
    end else begin
      fir_x   <= accept ? sample_in : 8'd0;
      tags[0] <= accept;
      for (int i = 1; i < FIR_LAT; i++) tags[i] <= tags[i-1];
    end
  end

  // State, counter and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      clap        <= 1'b0;
      double_clap <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      clap        <= clap_n;
      double_clap <= dbl_n;
    end
  end

  // Next-state logic; only tagged FIR outputs advance the counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clap_n  = 1'b0;
    dbl_n   = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          clap_n  = 1'b1;
          cnt_n   = HOLD_INIT;
          state_n = HOLD1;
        end
      end
      HOLD1: begin
        if (ov) begin
          if (cnt == 8'd1) begin
            cnt_n   = WIN_INIT;
            state_n = WIN;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      WIN: begin
        // A hit on the last window slot still wins over the timeout.
        if (hit) begin
          clap_n  = 1'b1;
          dbl_n   = 1'b1;
          cnt_n   = HOLD_INIT;
          state_n = HOLD2;
        end else if (ov) begin
          if (cnt == 8'd1) begin
            cnt_n   = 8'd0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      HOLD2: begin
        if (ov) begin
          if (cnt == 8'd1) begin
            cnt_n   = 8'd0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 8'd1;
          end
        end
      end
      default: begin
        cnt_n   = 8'd0;
        state_n = IDLE;
      end
    endcase
  end

  // Saturating clap counter; clear overrides a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clap_count <= 8'd0;
    end else if (clear_count) begin
      clap_count <= 8'd0;
    end else if (clap_n && (clap_count != 8'd255)) begin
      clap_count <= clap_count + 8'd1;
    end
  end

endmodule
